// File: rtl/fib_pkg.sv
// Shared types and constants for the Fibonacci stream generator.
package fib_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fib_state_t;

    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_STOP = 1'b1;

endpackage

// File: rtl/fib_stream_if.sv
// Valid/ready term stream carrying the current term value and its index.
interface fib_stream_if #(
    parameter int WIDTH = 32,
    parameter int IDX_W = 8
);
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_value;
    logic [IDX_W-1:0] out_index;

    modport master (
        output out_valid,
        output out_value,
        output out_index,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_value,
        input  out_index,
        output out_ready
    );
endinterface

// File: rtl/fib_prescaler.sv
// Free-running power-of-two prescaler; tick pulses once per 2^PRESCALE_LOG2 cycles.
module fib_prescaler #(
    parameter int PRESCALE_LOG2 = 20
) (
    input  logic clk,
    input  logic reset_n,
    output logic tick
);
    localparam logic [PRESCALE_LOG2-1:0] CNT_PRE_WRAP = {PRESCALE_LOG2{1'b1}} - PRESCALE_LOG2'(1);

    logic [PRESCALE_LOG2-1:0] cnt_r;
    logic                     tick_r;

    // Counter and registered tick, raised in the cycle the counter wraps.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_r  <= {PRESCALE_LOG2{1'b0}};
            tick_r <= 1'b0;
        end else begin
            cnt_r  <= cnt_r + PRESCALE_LOG2'(1);
            tick_r <= (cnt_r == CNT_PRE_WRAP);
        end
    end

    assign tick = tick_r;
endmodule

// File: rtl/fib_stream.sv
// Fibonacci term streamer with seeds, term limit and wrap/stop overflow modes.
// Optional feature: define FIB_PRESCALE_EN to pace terms with fib_prescaler.
module fib_stream
    import fib_pkg::*;
#(
    parameter int WIDTH         = 32,
    parameter int IDX_W         = 8,
    parameter int PRESCALE_LOG2 = 20
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [WIDTH-1:0]  seed0,
    input  logic [WIDTH-1:0]  seed1,
    input  logic              mode,
    input  logic [IDX_W-1:0]  count_limit,
    output logic              overflow,
    output logic              busy,
    output logic              done,
    fib_stream_if.master      stream
);

    fib_state_t       state_r, state_nxt;
    logic [WIDTH-1:0] a_r, a_nxt;
    logic [WIDTH-1:0] b_r, b_nxt;
    logic             b_c_r, b_c_nxt;
    logic [IDX_W-1:0] idx_r, idx_nxt;
    logic [IDX_W-1:0] limit_r, limit_nxt;
    logic             mode_r, mode_nxt;
    logic             ovf_r, ovf_nxt;
    logic             valid_r, valid_nxt;
    logic             busy_r, done_r;

    logic [WIDTH:0]   sum_s;
    logic             accept_s;
    logic             last_s;
    logic             tick_s;

`ifdef FIB_PRESCALE_EN
    fib_prescaler #(
        .PRESCALE_LOG2 (PRESCALE_LOG2)
    ) u_prescaler (
        .clk     (clk),
        .reset_n (reset_n),
        .tick    (tick_s)
    );
`else
    assign tick_s = 1'b1;
`endif

    assign sum_s    = {1'b0, a_r} + {1'b0, b_r};
    assign accept_s = valid_r & stream.out_ready;
    assign last_s   = (limit_r != {IDX_W{1'b0}}) && (idx_r == (limit_r - IDX_W'(1)));

    // Next-state and datapath: start beats any accept; limit beats overflow stop.
    always_comb begin
        state_nxt = state_r;
        a_nxt     = a_r;
        b_nxt     = b_r;
        b_c_nxt   = b_c_r;
        idx_nxt   = idx_r;
        limit_nxt = limit_r;
        mode_nxt  = mode_r;
        ovf_nxt   = ovf_r;
        valid_nxt = valid_r;

        if (start) begin
            state_nxt = RUN;
            a_nxt     = seed0;
            b_nxt     = seed1;
            b_c_nxt   = 1'b0;
            idx_nxt   = {IDX_W{1'b0}};
            limit_nxt = count_limit;
            mode_nxt  = mode;
            ovf_nxt   = 1'b0;
            valid_nxt = 1'b1;
        end else begin
            case (state_r)
                IDLE: begin
                    valid_nxt = 1'b0;
                end
                RUN: begin
                    if (accept_s) begin
                        // b_c_r flags the term about to move into a as wrapped
                        ovf_nxt = ovf_r | b_c_r;
                        if (last_s) begin
                            state_nxt = DONE;
                            valid_nxt = 1'b0;
                        end else if (b_c_r && (mode_r == MODE_STOP)) begin
                            state_nxt = DONE;
                            valid_nxt = 1'b0;
                        end else begin
                            a_nxt   = b_r;
                            b_nxt   = sum_s[WIDTH-1:0];
                            b_c_nxt = sum_s[WIDTH] | b_c_r;
                            idx_nxt = idx_r + IDX_W'(1);
`ifdef FIB_PRESCALE_EN
                            valid_nxt = 1'b0;
`else
                            valid_nxt = 1'b1;
`endif
                        end
                    end else if (!valid_r && tick_s) begin
                        valid_nxt = 1'b1;
                    end else begin
                        valid_nxt = valid_r;
                    end
                end
                DONE: begin
                    valid_nxt = 1'b0;
                end
                default: begin
                    state_nxt = IDLE;
                    valid_nxt = 1'b0;
                end
            endcase
        end
    end

    // State and datapath registers, with registered status outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= IDLE;
            a_r     <= {WIDTH{1'b0}};
            b_r     <= {WIDTH{1'b0}};
            b_c_r   <= 1'b0;
            idx_r   <= {IDX_W{1'b0}};
            limit_r <= {IDX_W{1'b0}};
            mode_r  <= MODE_WRAP;
            ovf_r   <= 1'b0;
            valid_r <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nxt;
            a_r     <= a_nxt;
            b_r     <= b_nxt;
            b_c_r   <= b_c_nxt;
            idx_r   <= idx_nxt;
            limit_r <= limit_nxt;
            mode_r  <= mode_nxt;
            ovf_r   <= ovf_nxt;
            valid_r <= valid_nxt;
            busy_r  <= (state_nxt == RUN);
            done_r  <= (state_nxt == DONE);
        end
    end

    assign stream.out_valid = valid_r;
    assign stream.out_value = a_r;
    assign stream.out_index = idx_r;
    assign overflow         = ovf_r;
    assign busy             = busy_r;
    assign done             = done_r;

endmodule

// File: tb/tb_fib_stream.sv
// Directed bench for fib_stream: 32-bit and 8-bit instances, hand-computed terms.
module tb_fib_stream;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start32, start8, mode;
    logic [31:0] s0_32, s1_32;
    logic [7:0]  s0_8, s1_8, limit;
    logic        ovf32, busy32, done32;
    logic        ovf8, busy8, done8;

    int vec_cnt = 0;
    int err_cnt = 0;

    // Fibonacci 0/1 terms; entry 14 is 377 mod 256 for the 8-bit instance.
    logic [31:0] fib_tab [15] = '{32'd0, 32'd1, 32'd1, 32'd2, 32'd3, 32'd5, 32'd8, 32'd13,
                                  32'd21, 32'd34, 32'd55, 32'd89, 32'd144, 32'd233, 32'd121};
    logic [31:0] lucas_tab [6] = '{32'd2, 32'd1, 32'd3, 32'd4, 32'd7, 32'd11};

    always #5 clk = ~clk;

    fib_stream_if #(.WIDTH(32), .IDX_W(8)) if32 ();
    fib_stream_if #(.WIDTH(8),  .IDX_W(8)) if8 ();

    fib_stream #(.WIDTH(32), .IDX_W(8)) u_fib32 (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start32),
        .seed0       (s0_32),
        .seed1       (s1_32),
        .mode        (mode),
        .count_limit (limit),
        .overflow    (ovf32),
        .busy        (busy32),
        .done        (done32),
        .stream      (if32)
    );

    fib_stream #(.WIDTH(8), .IDX_W(8)) u_fib8 (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start8),
        .seed0       (s0_8),
        .seed1       (s1_8),
        .mode        (mode),
        .count_limit (limit),
        .overflow    (ovf8),
        .busy        (busy8),
        .done        (done8),
        .stream      (if8)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n = 1'b0;
        start32 = 1'b0; start8 = 1'b0; mode = 1'b0;
        s0_32 = 32'd0; s1_32 = 32'd0; s0_8 = 8'd0; s1_8 = 8'd0; limit = 8'd0;
        if32.out_ready = 1'b1;
        if8.out_ready  = 1'b1;
        step(); step();

        check_val("rst valid", {31'd0, if32.out_valid}, 32'd0);
        check_val("rst value", if32.out_value, 32'd0);
        check_val("rst busy",  {31'd0, busy32}, 32'd0);
        check_val("rst done",  {31'd0, done32}, 32'd0);
        check_val("rst ovf",   {31'd0, ovf32}, 32'd0);
        reset_n = 1'b1;
        step(); step();
        check_val("idle valid", {31'd0, if32.out_valid}, 32'd0);

        // Seeds 0/1, limit 7: one term per cycle, then DONE.
        s0_32 = 32'd0; s1_32 = 32'd1; limit = 8'd7; mode = 1'b0;
        start32 = 1'b1; step(); start32 = 1'b0;
        for (int k = 0; k < 7; k++) begin
            check_val($sformatf("fib val %0d", k), if32.out_value, fib_tab[k]);
            check_val($sformatf("fib idx %0d", k), {24'd0, if32.out_index}, k);
            check_val($sformatf("fib vld %0d", k), {31'd0, if32.out_valid}, 32'd1);
            check_val($sformatf("fib busy %0d", k), {31'd0, busy32}, 32'd1);
            step();
        end
        check_val("fib done",  {31'd0, done32}, 32'd1);
        check_val("fib vld end", {31'd0, if32.out_valid}, 32'd0);
        check_val("fib busy end", {31'd0, busy32}, 32'd0);

        // Lucas seeds restarted from DONE, limit 6.
        s0_32 = 32'd2; s1_32 = 32'd1; limit = 8'd6;
        start32 = 1'b1; step(); start32 = 1'b0;
        for (int k = 0; k < 6; k++) begin
            check_val($sformatf("lucas val %0d", k), if32.out_value, lucas_tab[k]);
            step();
        end
        check_val("lucas done", {31'd0, done32}, 32'd1);
        check_val("lucas ovf",  {31'd0, ovf32}, 32'd0);

        // 8-bit stop mode: 233 at idx 13 is the last term.
        s0_8 = 8'd0; s1_8 = 8'd1; limit = 8'd0; mode = 1'b1;
        start8 = 1'b1; step(); start8 = 1'b0;
        for (int k = 0; k < 14; k++) begin
            check_val($sformatf("stop val %0d", k), {24'd0, if8.out_value}, fib_tab[k]);
            check_val($sformatf("stop idx %0d", k), {24'd0, if8.out_index}, k);
            step();
        end
        check_val("stop done", {31'd0, done8}, 32'd1);
        check_val("stop vld",  {31'd0, if8.out_valid}, 32'd0);
        check_val("stop ovf",  {31'd0, ovf8}, 32'd1);

        // 8-bit wrap mode: idx 14 carries 121 and the stream keeps going.
        mode = 1'b0;
        start8 = 1'b1; step(); start8 = 1'b0;
        check_val("wrap ovf clr", {31'd0, ovf8}, 32'd0);
        for (int k = 0; k < 15; k++) begin
            check_val($sformatf("wrap val %0d", k), {24'd0, if8.out_value}, fib_tab[k]);
            if (k == 13) check_val("wrap ovf 13", {31'd0, ovf8}, 32'd0);
            if (k == 14) check_val("wrap ovf 14", {31'd0, ovf8}, 32'd1);
            step();
        end
        check_val("wrap val 15", {24'd0, if8.out_value}, 32'd98);
        check_val("wrap vld 15", {31'd0, if8.out_valid}, 32'd1);
        check_val("wrap busy",   {31'd0, busy8}, 32'd1);

        // Backpressure on term 5, then a start with ready high.
        s0_32 = 32'd0; s1_32 = 32'd1; limit = 8'd0;
        start32 = 1'b1; step(); start32 = 1'b0;
        repeat (5) step();
        check_val("bp val", if32.out_value, 32'd5);
        if32.out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            check_val($sformatf("hold val %0d", k), if32.out_value, 32'd5);
            check_val($sformatf("hold idx %0d", k), {24'd0, if32.out_index}, 32'd5);
            check_val($sformatf("hold vld %0d", k), {31'd0, if32.out_valid}, 32'd1);
        end
        if32.out_ready = 1'b1;
        step();
        check_val("bp next val", if32.out_value, 32'd8);
        check_val("bp next idx", {24'd0, if32.out_index}, 32'd6);
        s0_32 = 32'd3; s1_32 = 32'd4;
        start32 = 1'b1; step(); start32 = 1'b0;
        check_val("restart val", if32.out_value, 32'd3);
        check_val("restart idx", {24'd0, if32.out_index}, 32'd0);
        step();
        check_val("restart val1", if32.out_value, 32'd4);

        // Asynchronous reset at idx 4, then stay idle.
        s0_32 = 32'd0; s1_32 = 32'd1;
        start32 = 1'b1; step(); start32 = 1'b0;
        repeat (4) step();
        check_val("pre rst val", if32.out_value, 32'd3);
        #1 reset_n = 1'b0;
        #2;
        check_val("arst vld",  {31'd0, if32.out_valid}, 32'd0);
        check_val("arst val",  if32.out_value, 32'd0);
        check_val("arst idx",  {24'd0, if32.out_index}, 32'd0);
        check_val("arst busy", {31'd0, busy32}, 32'd0);
        check_val("arst done", {31'd0, done32}, 32'd0);
        #2 reset_n = 1'b1;
        repeat (3) step();
        check_val("post rst vld",  {31'd0, if32.out_valid}, 32'd0);
        check_val("post rst busy", {31'd0, busy32}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/fib_stream.md
FIB_STREAM -- requirements
Module: fib_stream

Interface
REQ-001 SHALL have parameter WIDTH, default 32, term width in bits.
REQ-002 SHALL have parameter IDX_W, default 8, term-index and limit width.
REQ-003 SHALL have parameter PRESCALE_LOG2, default 20, log2 of prescaler period; used only under FIB_PRESCALE_EN.
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port start  input  1  one-cycle pulse; loads seeds and begins a sequence.
REQ-007 SHALL have port seed0  input  WIDTH  first term, sampled on start.
REQ-008 SHALL have port seed1  input  WIDTH  second term, sampled on start.
REQ-009 SHALL have port mode  input  1  0 = wrap on overflow, 1 = stop on overflow; sampled on start.
REQ-010 SHALL have port count_limit  input  IDX_W  terms to emit, 0 = unbounded; sampled on start.
REQ-011 SHALL have port out_valid  output  1  out_value/out_index hold a term.
REQ-012 SHALL have port out_ready  input  1  consumer accepts the term.
REQ-013 SHALL have port out_value  output  WIDTH  current term.
REQ-014 SHALL have port out_index  output  IDX_W  index of current term, first term = 0.
REQ-015 SHALL have port overflow  output  1  sticky; a term wrapped past 2^WIDTH.
REQ-016 SHALL have port busy  output  1  high in RUN.
REQ-017 SHALL have port done  output  1  high in DONE.

Function
REQ-018 SHALL implement states IDLE, RUN, DONE; IDLE -> RUN on start; RUN -> DONE on limit or stop-on-overflow; DONE -> RUN on start.
REQ-019 On start SHALL load a=seed0, b=seed1, idx=0, overflow=0, and latch mode and count_limit; out_valid high the next cycle with out_value=seed0.
REQ-020 Accept = out_valid & out_ready; on accept: a<=b, b<=(a+b) mod 2^WIDTH, idx<=idx+1.
REQ-021 SHALL track a carry flag with b (carry of a+b OR the carry flag of b); it moves with b into a.
REQ-022 On accept, if the term moving into a carries the flag: mode 0 -> continue, set overflow; mode 1 -> enter DONE, set overflow, wrapped term never emitted.
REQ-023 On accept with count_limit!=0 and idx==count_limit-1 SHALL enter DONE; limit takes precedence over overflow stop.
REQ-024 out_value/out_index SHALL remain stable while out_valid & !out_ready; out_valid SHALL never drop without an accept, except on start or reset.
REQ-025 Without prescaler, throughput SHALL be one term per cycle with out_ready held high.
REQ-026 start in RUN SHALL restart immediately; start in the same cycle as an accept SHALL win; the accepted term is discarded.
REQ-027 idx SHALL wrap modulo 2^IDX_W when unbounded.
REQ-028 out_valid SHALL be low in IDLE and DONE; busy = (state==RUN); done = (state==DONE).

Reset
REQ-029 reset_n low SHALL asynchronously force IDLE, a=b=0, idx=0, carry=0, overflow=0, out_valid=0, busy=0, done=0, prescaler=0.
REQ-030 Reset mid-sequence SHALL discard the sequence; after release, nothing is emitted until start.

Configuration
REQ-031 With FIB_PRESCALE_EN defined, a free-running PRESCALE_LOG2-bit counter SHALL produce tick once per 2^PRESCALE_LOG2 cycles; after each accept out_valid SHALL stay low until the next tick, then reassert. The first term after start is not gated.
REQ-032 Without FIB_PRESCALE_EN, no prescaler counter SHALL exist and REQ-025 applies.

Structure
REQ-033 A shared package fib_pkg SHALL hold the state enum (IDLE, RUN, DONE) and the mode constants MODE_WRAP=0 and MODE_STOP=1.
REQ-034 The prescaler SHALL be a sub-module fib_prescaler (output tick), instantiated only under FIB_PRESCALE_EN.

Verification
REQ-035 WIDTH=32, seeds 0/1, limit 7, ready high -> values 0,1,1,2,3,5,8 at idx 0..6 on consecutive cycles; then done=1, out_valid=0.
REQ-036 Seeds 2/1 (Lucas), limit 6 -> values 2,1,3,4,7,11; overflow=0.
REQ-037 WIDTH=8, mode 1, seeds 0/1, limit 0 -> last term 233 at idx 13; DONE follows, overflow=1, 121 never emitted.
REQ-038 WIDTH=8, mode 0, same seeds -> idx 14 emits 121 (377 mod 256); overflow=1; sequence continues.
REQ-039 Ready low 3 cycles on term 5 -> value, idx and valid held; the next accept yields 8; a start pulse with ready high reloads the seeds next cycle.
REQ-040 reset_n low for 1 cycle at idx 4 -> all outputs 0 asynchronously; idle until start.
